csr_exec: RTL

Sequencing stage between the decode/issue stage and the CSR register file for Zicsr instructions (CSRRW/RS/RC and immediate forms). Accepts one decoded CSR instruction over a valid/ready handshake and performs a registered read of the CSR file. Computes the read-modify-write value, then issues a single write pulse to the CSR file and a single writeback pulse to the GPR file. It also flags illegal CSR accesses to the trap logic.

---
 rtl/csr_exec.sv | 135 +++++++++++++
 1 files changed

// File: rtl/csr_exec.sv
// Zicsr sequencer: accepts one CSR instruction, reads the CSR file, then pulses the CSR write and GPR writeback.
// Optional macro CSR_RO_CHECK_EN makes write attempts to read-only CSRs (addr[11:10]==2'b11) illegal.
module csr_exec #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [11:0]     i_csr_addr,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rs1_addr_uimm,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  output logic [11:0]     o_csr_raddr,
  output logic            o_csr_ren,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic [11:0]     o_csr_waddr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_csr_wen,
  output logic            o_rd_we,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_illegal,
  output logic [1:0]      o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]      state;
  logic [11:0]     addr_q;
  logic [1:0]      op_q;
  logic [4:0]      field_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] operand_q;

  logic            accept;
  logic            do_read_in;
  logic [XLEN-1:0] operand_in;
  logic            do_write;
  logic            ro_viol;
  logic            illegal;

  // Handshake: a transfer happens on a rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE and never while reset is asserted.
  assign o_ready     = (state == S_IDLE) && i_nrst;
  assign accept      = i_valid && o_ready;
  assign o_dbg_state = state;

  assign do_read_in = (i_funct3[1:0] == 2'b01) ? (i_rd_addr != 5'd0) : 1'b1;
  assign operand_in = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_rs1_addr_uimm} : i_rs1_data;

  assign do_write = (op_q == 2'b01) ? 1'b1 : (field_q != 5'd0);

`ifdef CSR_RO_CHECK_EN
  assign ro_viol = (addr_q[11:10] == 2'b11) && do_write;
`else
  assign ro_viol = 1'b0;
`endif

  // funct3 of 3'b000 / 3'b100 both leave the low two bits zero.
  assign illegal = (op_q == 2'b00) || ro_viol;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      field_q     <= '0;
      rd_q        <= '0;
      operand_q   <= '0;
      o_csr_ren   <= 1'b0;
      o_csr_raddr <= '0;
      o_csr_wen   <= 1'b0;
      o_csr_waddr <= '0;
      o_rd_we     <= 1'b0;
      o_rd_addr   <= '0;
      o_illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_RD;
            addr_q      <= i_csr_addr;
            op_q        <= i_funct3[1:0];
            field_q     <= i_rs1_addr_uimm;
            rd_q        <= i_rd_addr;
            operand_q   <= operand_in;
            o_csr_ren   <= do_read_in;
            o_csr_raddr <= i_csr_addr;
          end
        end
        S_RD: begin
          state       <= S_WB;
          o_csr_ren   <= 1'b0;
          o_csr_raddr <= '0;
          o_csr_wen   <= !illegal && do_write;
          o_rd_we     <= !illegal && (rd_q != 5'd0);
          o_illegal   <= illegal;
          o_csr_waddr <= addr_q;
          o_rd_addr   <= rd_q;
        end
        S_WB: begin
          state       <= S_IDLE;
          o_csr_wen   <= 1'b0;
          o_rd_we     <= 1'b0;
          o_illegal   <= 1'b0;
          o_csr_waddr <= '0;
          o_rd_addr   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Old CSR value arrives during WB, so the new value is formed combinationally there.
  always_comb begin
    o_csr_wdata = '0;
    o_rd_data   = '0;
    if (o_csr_wen) begin
      case (op_q)
        2'b01:   o_csr_wdata = operand_q;
        2'b10:   o_csr_wdata = i_csr_rdata | operand_q;
        2'b11:   o_csr_wdata = i_csr_rdata & ~operand_q;
        default: o_csr_wdata = '0;
      endcase
    end
    if (o_rd_we) begin
      o_rd_data = i_csr_rdata;
    end
  end

endmodule
